// File: rtl/fixed_to_pixel_if.sv
// Sample stream into and pixel stream out of fixed_to_pixel.
// Each channel occupies its own slice of the packed buses.
interface fixed_to_pixel_if #(
  parameter int WIDTH_FIXED = 15,
  parameter int WIDTH_PIX   = 8,
  parameter int N_CH        = 2
);
  logic                        in_valid;
  logic [N_CH*WIDTH_FIXED-1:0] out_cenn;
  logic                        out_valid;
  logic [N_CH*WIDTH_PIX-1:0]   black_white;

  modport master (
    output in_valid, out_cenn,
    input  out_valid, black_white
  );

  modport slave (
    input  in_valid, out_cenn,
    output out_valid, black_white
  );
endinterface

// File: rtl/fixed_to_pixel.sv
// Converts signed fixed-point CeNN cell outputs to pixel intensities.
// Uses either a button-stepped threshold or a linear grayscale map, through a two-stage pipeline.
module fixed_to_pixel #(
  parameter int WIDTH_FIXED = 15,
  parameter int FRAC_BITS   = 9,
  parameter int WIDTH_PIX   = 8,
  parameter int N_CH        = 2,
  parameter int LEVEL_BITS  = 5,
  parameter int STEP_SHIFT  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ready_signal,
  input  logic                   press_down,
  input  logic                   press_up,
  input  logic                   mode,
  fixed_to_pixel_if.slave        bus,
  output logic [LEVEL_BITS-1:0]  led,
  output logic [WIDTH_FIXED-1:0] threshold_out
);

  localparam logic [LEVEL_BITS-1:0]         MID      = LEVEL_BITS'(1 << (LEVEL_BITS-1));
  localparam logic [LEVEL_BITS-1:0]         IDX_MAX  = '1;
  localparam int unsigned                   GS_SHIFT = FRAC_BITS + 1 - WIDTH_PIX;
  localparam logic signed [WIDTH_FIXED+1:0] ONE_FX   = (WIDTH_FIXED+2)'(1 << FRAC_BITS);
  localparam logic signed [WIDTH_FIXED+1:0] PIX_MAX  = (WIDTH_FIXED+2)'((1 << WIDTH_PIX) - 1);

  logic [LEVEL_BITS-1:0]         index;
  logic signed [LEVEL_BITS:0]    idx_off;
  logic signed [WIDTH_FIXED-1:0] thr;

  logic                          v1;
  logic [N_CH*WIDTH_FIXED-1:0]   x1;
  logic                          mode1;
  logic signed [WIDTH_FIXED-1:0] thr1;

  logic [N_CH*WIDTH_PIX-1:0]     pix_nxt;
  logic [N_CH*WIDTH_PIX-1:0]     bw_q;
  logic                          ov_q;

  // Simultaneous up and down presses cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= MID;
      led   <= MID;
    end else begin
      led <= index;
      if (!ready_signal)
        index <= MID;
      else if (press_down && !press_up && index != '0)
        index <= index - 1'b1;
      else if (press_up && !press_down && index != IDX_MAX)
        index <= index + 1'b1;
    end
  end

  always_comb begin
    idx_off = signed'({1'b0, index}) - signed'({1'b0, MID});
    thr     = WIDTH_FIXED'(idx_off) <<< STEP_SHIFT;
  end

  assign threshold_out = thr;

  // Threshold and mode travel with the sample so in-flight data keeps its settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      x1    <= '0;
      mode1 <= 1'b0;
      thr1  <= '0;
    end else begin
      v1    <= bus.in_valid & ready_signal;
      x1    <= bus.out_cenn;
      mode1 <= mode;
      thr1  <= thr;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [WIDTH_FIXED-1:0] xc;
    logic signed [WIDTH_FIXED+1:0] t;
    logic [WIDTH_PIX-1:0]          pix;

    always_comb begin
      xc  = signed'(x1[c*WIDTH_FIXED +: WIDTH_FIXED]);
      t   = (ONE_FX - (WIDTH_FIXED+2)'(xc)) >>> GS_SHIFT;
      pix = '0;
      if (!mode1)
        pix = (xc > thr1) ? '0 : '1;
      else if (t < 0)
        pix = '0;
      else if (t > PIX_MAX)
        pix = '1;
      else
        pix = t[WIDTH_PIX-1:0];
    end

    assign pix_nxt[c*WIDTH_PIX +: WIDTH_PIX] = pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      bw_q <= '0;
    end else begin
      ov_q <= v1 & ready_signal;
      if (v1 && ready_signal)
        bw_q <= pix_nxt;
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.black_white = bw_q;

endmodule
